rv32i_inst_encoder: RTL and testbench

Streaming RV32I instruction encoder, the inverse of the package's field decode: accepts decoded instruction fields (opcode, registers, funct fields, full 32-bit immediate) over a valid/ready stream and emits the packed 32-bit instruction word. It also flags immediates that cannot be represented in the target format. It sits in test/boot infrastructure: program generators, the debug-module instruction injector, and round-trip checks against the decoder.

---
 rtl/rv32i_inst_encoder_pkg.sv | 166 ++++++++++++++++
 rtl/rv32i_inst_encoder_if.sv | 35 +++
 rtl/rv32i_inst_encoder_stream_stage.sv | 34 +++
 rtl/rv32i_inst_encoder.sv | 113 +++++++++++
 tb/tb_rv32i_inst_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_inst_encoder_pkg.sv
// RV32I field types, immediate range checks and
// the field encode/decode pair used by the encoder.
package rv32i_inst_encoder_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OPIMM  = 7'h13,
    OPC_OP     = 7'h33,
    OPC_SYSTEM = 7'h73
  } rv32i_opcode_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } rv32_fields_t;

  localparam int FieldsW = $bits(rv32_fields_t);

  function automatic logic all_same21(
    input logic [20:0] v
  );
    return (&v) || !(|v);
  endfunction

  function automatic logic fits_simm12(
    input logic [20:0] hi
  );
    return all_same21(hi);
  endfunction

  function automatic logic fits_b(
    input logic [19:0] hi,
    input logic        lsb
  );
    return !lsb && ((&hi) || !(|hi));
  endfunction

  function automatic logic fits_j(
    input logic [11:0] hi,
    input logic        lsb
  );
    return !lsb && ((&hi) || !(|hi));
  endfunction

  function automatic logic fits_u(
    input logic [11:0] lo
  );
    return !(|lo);
  endfunction

  function automatic logic fits_shamt(
    input logic [26:0] hi
  );
    return !(|hi);
  endfunction

  function automatic logic is_shift(
    input logic [2:0] f3
  );
    return (f3 == 3'd1) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0]
    rv32_encode_fields(input rv32_fields_t f);
    logic [31:0] w;
    w = '0;
    case (f.opcode)
      OPC_OP:
        w = {f.funct7, f.rs2, f.rs1,
             f.funct3, f.rd, f.opcode};
      OPC_OPIMM:
        if (is_shift(f.funct3))
          w = {f.funct7, f.imm[4:0], f.rs1,
               f.funct3, f.rd, f.opcode};
        else
          w = {f.imm[11:0], f.rs1,
               f.funct3, f.rd, f.opcode};
      OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        w = {f.imm[11:0], f.rs1,
             f.funct3, f.rd, f.opcode};
      OPC_STORE:
        w = {f.imm[11:5], f.rs2, f.rs1,
             f.funct3, f.imm[4:0], f.opcode};
      OPC_BRANCH:
        w = {f.imm[12], f.imm[10:5], f.rs2,
             f.rs1, f.funct3, f.imm[4:1],
             f.imm[11], f.opcode};
      OPC_LUI, OPC_AUIPC:
        w = {f.imm[31:12], f.rd, f.opcode};
      OPC_JAL:
        w = {f.imm[20], f.imm[10:1], f.imm[11],
             f.imm[19:12], f.rd, f.opcode};
      default:
        w = '0;
    endcase
    return w;
  endfunction

  // Fields a format does not carry decode as zero.
  function automatic rv32_fields_t
    rv32_get_fields(input logic [31:0] w);
    rv32_fields_t f;
    f = '0;
    f.opcode = w[6:0];
    case (w[6:0])
      OPC_OP: begin
        f.rd = w[11:7];
        f.rs1 = w[19:15];
        f.rs2 = w[24:20];
        f.funct3 = w[14:12];
        f.funct7 = w[31:25];
      end
      OPC_OPIMM, OPC_LOAD,
      OPC_JALR, OPC_SYSTEM: begin
        f.rd = w[11:7];
        f.rs1 = w[19:15];
        f.funct3 = w[14:12];
        if (w[6:0] == OPC_OPIMM &&
            is_shift(w[14:12])) begin
          f.funct7 = w[31:25];
          f.imm = {27'b0, w[24:20]};
        end else begin
          f.imm = {{20{w[31]}}, w[31:20]};
        end
      end
      OPC_STORE: begin
        f.rs1 = w[19:15];
        f.rs2 = w[24:20];
        f.funct3 = w[14:12];
        f.imm = {{20{w[31]}}, w[31:25],
                 w[11:7]};
      end
      OPC_BRANCH: begin
        f.rs1 = w[19:15];
        f.rs2 = w[24:20];
        f.funct3 = w[14:12];
        f.imm = {{19{w[31]}}, w[31], w[7],
                 w[30:25], w[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        f.rd = w[11:7];
        f.imm = {w[31:12], 12'b0};
      end
      OPC_JAL: begin
        f.rd = w[11:7];
        f.imm = {{11{w[31]}}, w[31],
                 w[19:12], w[20],
                 w[30:21], 1'b0};
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_inst_encoder_if.sv
// Stream bundle between a field producer and the
// encoder: field input, encoded output, counters.
interface rv32i_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_error;
  logic [31:0] inst_count;
  logic [31:0] error_count;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_imm,
           out_ready,
    input  in_ready, out_valid, out_inst,
           out_error, inst_count, error_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_imm,
           out_ready,
    output in_ready, out_valid, out_inst,
           out_error, inst_count, error_count
  );
endinterface

// File: rtl/rv32i_inst_encoder_stream_stage.sv
// One valid+payload pipeline register with
// load-when-empty-or-draining ready logic.
module rv32_stream_stage #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid)
        r_data <= i_data;
    end
  end
endmodule

// File: rtl/rv32i_inst_encoder.sv
// Two-stage RV32I encoder: S1 range-checks the
// immediate, S2 packs the instruction word.
module rv32i_inst_encoder
  import rv32i_inst_encoder_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  rv32i_inst_encoder_if.slave bus
);
  localparam int S1W = FieldsW + 1;

  rv32_fields_t   w_in_f;
  logic           w_in_err;
  logic [S1W-1:0] w_s1_d;
  logic [S1W-1:0] w_s1_q;
  logic           w_s1_v;
  logic           w_s1_rdy;
  rv32_fields_t   w_s1_f;
  logic [32:0]    w_s2_d;
  logic [32:0]    w_s2_q;
  logic           w_s2_v;
  logic           w_s2_rdy;
  logic           w_fire;
  logic [31:0]    r_inst_cnt;
  logic [31:0]    r_err_cnt;

  always_comb begin
    w_in_f.opcode = bus.in_opcode;
    w_in_f.rd     = bus.in_rd;
    w_in_f.rs1    = bus.in_rs1;
    w_in_f.rs2    = bus.in_rs2;
    w_in_f.funct3 = bus.in_funct3;
    w_in_f.funct7 = bus.in_funct7;
    w_in_f.imm    = bus.in_imm;
  end

  always_comb begin
    w_in_err = 1'b1;
    case (bus.in_opcode)
      OPC_OP:
        w_in_err = 1'b0;
      OPC_OPIMM:
        if (is_shift(bus.in_funct3))
          w_in_err =
            !fits_shamt(bus.in_imm[31:5]);
        else
          w_in_err =
            !fits_simm12(bus.in_imm[31:11]);
      OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_STORE:
        w_in_err =
          !fits_simm12(bus.in_imm[31:11]);
      OPC_BRANCH:
        w_in_err = !fits_b(bus.in_imm[31:12],
                           bus.in_imm[0]);
      OPC_JAL:
        w_in_err = !fits_j(bus.in_imm[31:20],
                           bus.in_imm[0]);
      OPC_LUI, OPC_AUIPC:
        w_in_err = !fits_u(bus.in_imm[11:0]);
      default:
        w_in_err = 1'b1;
    endcase
  end

  assign w_s1_d = {w_in_f, w_in_err};
  assign w_s1_f = w_s1_q[S1W-1:1];
  assign w_s2_d = {rv32_encode_fields(w_s1_f),
                   w_s1_q[0]};

  rv32_stream_stage #(.W(S1W)) u_s1 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_s1_rdy),
    .i_data  (w_s1_d),
    .o_valid (w_s1_v),
    .o_data  (w_s1_q),
    .i_ready (w_s2_rdy)
  );

  rv32_stream_stage #(.W(33)) u_s2 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (w_s1_v),
    .o_ready (w_s2_rdy),
    .i_data  (w_s2_d),
    .o_valid (w_s2_v),
    .o_data  (w_s2_q),
    .i_ready (bus.out_ready)
  );

  // Hold off producers for the whole reset cycle.
  assign bus.in_ready  = rst && w_s1_rdy;
  assign bus.out_valid = w_s2_v;
  assign bus.out_inst  = w_s2_q[32:1];
  assign bus.out_error = w_s2_q[0];
  assign w_fire        = w_s2_v && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inst_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_fire) begin
      r_inst_cnt <= r_inst_cnt + 32'd1;
      if (w_s2_q[0])
        r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign bus.inst_count  = r_inst_cnt;
  assign bus.error_count = r_err_cnt;
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed and round-trip checks for the
// streaming RV32I instruction encoder.
module tb_rv32i_inst_encoder;
  import rv32i_inst_encoder_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [31:0] exp_ic;
  logic [31:0] exp_ec;

  rv32i_inst_encoder_if bus ();

  rv32i_inst_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  function automatic rv32_fields_t mk(
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    rv32_fields_t f;
    f.opcode = op;
    f.rd = rd;
    f.rs1 = rs1;
    f.rs2 = rs2;
    f.funct3 = f3;
    f.funct7 = f7;
    f.imm = imm;
    return f;
  endfunction

  task automatic drive(
    input rv32_fields_t f,
    input logic         v
  );
    bus.in_opcode = f.opcode;
    bus.in_rd     = f.rd;
    bus.in_rs1    = f.rs1;
    bus.in_rs2    = f.rs2;
    bus.in_funct3 = f.funct3;
    bus.in_funct7 = f.funct7;
    bus.in_imm    = f.imm;
    bus.in_valid  = v;
  endtask

  task automatic run_one(
    input string        tag,
    input rv32_fields_t f,
    input logic [31:0]  ei,
    input logic         ee
  );
    int n;
    int lat;
    @(negedge clk);
    drive(f, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_acc"}, 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(2));
    chk({tag, "_inst"}, 64'(bus.out_inst), 64'(ei));
    chk({tag, "_err"}, 64'(bus.out_error), 64'(ee));
    exp_ic = exp_ic + 32'd1;
    exp_ec = exp_ec + 32'(ee);
    @(negedge clk);
    #1;
    chk({tag, "_icnt"}, 64'(bus.inst_count),
        64'(exp_ic));
    chk({tag, "_ecnt"}, 64'(bus.error_count),
        64'(exp_ec));
  endtask

  function automatic logic [31:0] sx12();
    logic [11:0] r;
    r = 12'($urandom);
    return {{20{r[11]}}, r};
  endfunction

  function automatic rv32_fields_t gen_legal();
    rv32_fields_t f;
    logic [6:0] ops [10];
    logic [12:0] b;
    logic [20:0] j;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_OPIMM, OPC_OP, OPC_SYSTEM};
    f = '0;
    f.opcode = ops[$urandom_range(0, 9)];
    b = {13'($urandom) >> 1, 1'b0};
    j = {21'($urandom) >> 1, 1'b0};
    case (f.opcode)
      OPC_OP: begin
        f.rd = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.funct3 = 3'($urandom);
        f.funct7 = 7'($urandom);
      end
      OPC_OPIMM, OPC_LOAD,
      OPC_JALR, OPC_SYSTEM: begin
        f.rd = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.funct3 = 3'($urandom);
        if (f.opcode == OPC_OPIMM &&
            (f.funct3 == 3'd1 ||
             f.funct3 == 3'd5)) begin
          f.imm = 32'($urandom_range(0, 31));
          if (f.funct3 == 3'd5 && $urandom_range(0, 1) == 1)
            f.funct7 = 7'h20;
        end else begin
          f.imm = sx12();
        end
      end
      OPC_STORE: begin
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.funct3 = 3'($urandom);
        f.imm = sx12();
      end
      OPC_BRANCH: begin
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.funct3 = 3'($urandom);
        f.imm = {{19{b[12]}}, b};
      end
      OPC_LUI, OPC_AUIPC: begin
        f.rd = 5'($urandom);
        f.imm = $urandom & 32'hFFFF_F000;
      end
      default: begin
        f.rd = 5'($urandom);
        f.imm = {{11{j[20]}}, j};
      end
    endcase
    return f;
  endfunction

  rv32_fields_t bp [3];
  logic [31:0]  bpe [3];
  logic [31:0]  got [$];
  rv32_fields_t rtq [$];
  rv32_fields_t cur;
  int idx;
  int n;
  int sent;
  int rcv;
  int rt_bad;

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_ic = '0;
    exp_ec = '0;
    rst = 1'b0;
    drive('0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_oval", 64'(bus.out_valid), 64'(0));
    chk("rst_inst", 64'(bus.out_inst), 64'(0));
    chk("rst_oerr", 64'(bus.out_error), 64'(0));
    chk("rst_icnt", 64'(bus.inst_count), 64'(0));
    chk("rst_ecnt", 64'(bus.error_count), 64'(0));
    chk("rst_irdy", 64'(bus.in_ready), 64'(0));
    rst = 1'b1;

    run_one("addi", mk(7'h13, 5'd1, 5'd0, 5'd0,
            3'd0, 7'd0, 32'hFFFF_FFFF),
            32'hFFF0_0093, 1'b0);
    run_one("sw", mk(7'h23, 5'd0, 5'd3, 5'd2,
            3'd2, 7'd0, 32'd8),
            32'h0021_A423, 1'b0);
    run_one("jal", mk(7'h6F, 5'd1, 5'd0, 5'd0,
            3'd0, 7'd0, 32'h800),
            32'h0010_00EF, 1'b0);
    run_one("beq_odd", mk(7'h63, 5'd0, 5'd0, 5'd0,
            3'd0, 7'd0, 32'd3),
            32'h0000_0163, 1'b1);
    run_one("lui_bad", mk(7'h37, 5'd0, 5'd0, 5'd0,
            3'd0, 7'd0, 32'h1234_5001),
            32'h1234_5037, 1'b1);
    run_one("unk", mk(7'h7F, 5'd1, 5'd2, 5'd3,
            3'd1, 7'd1, 32'd0),
            32'h0, 1'b1);
    run_one("lui", mk(7'h37, 5'd5, 5'd0, 5'd0,
            3'd0, 7'd0, 32'h1234_5000),
            32'h1234_52B7, 1'b0);
    run_one("srai", mk(7'h13, 5'd3, 5'd4, 5'd0,
            3'd5, 7'h20, 32'd7),
            32'h4072_5193, 1'b0);
    run_one("slli_big", mk(7'h13, 5'd1, 5'd1, 5'd0,
            3'd1, 7'h00, 32'h20),
            32'h0000_9093, 1'b1);

    // backpressure
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_ic = '0;
    exp_ec = '0;
    for (int i = 0; i < 3; i++) begin
      bp[i] = mk(7'h13, 5'(i + 1), 5'd0, 5'd0,
                 3'd0, 7'd0, 32'(i + 1));
    end
    bpe[0] = 32'h0010_0093;
    bpe[1] = 32'h0020_0113;
    bpe[2] = 32'h0030_0193;
    idx = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(bp[idx < 3 ? idx : 0], idx < 3);
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
    end
    chk("bp_acc", 64'(idx), 64'(2));
    chk("bp_irdy", 64'(bus.in_ready), 64'(0));
    chk("bp_oval", 64'(bus.out_valid), 64'(1));
    chk("bp_hold", 64'(bus.out_inst), 64'(bpe[0]));
    n = 0;
    while (got.size() < 3 && n < 40) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(bp[idx < 3 ? idx : 0], idx < 3);
      #1;
      if (bus.out_valid && bus.out_ready)
        got.push_back(bus.out_inst);
      if (bus.in_valid && bus.in_ready) idx++;
      n++;
    end
    chk("bp_cnt", 64'(got.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < got.size())
        chk($sformatf("bp_out%0d", i),
            64'(got[i]), 64'(bpe[i]));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("bp_nodup", 64'(bus.out_valid), 64'(0));
    chk("bp_icnt", 64'(bus.inst_count), 64'(3));

    // reset with both stages full
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(bp[idx < 3 ? idx : 0], idx < 3);
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
    end
    chk("rm_full", 64'(idx), 64'(2));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_irdy", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("rm_oval", 64'(bus.out_valid), 64'(0));
    chk("rm_icnt", 64'(bus.inst_count), 64'(0));
    chk("rm_ecnt", 64'(bus.error_count), 64'(0));
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_ic = '0;
    exp_ec = '0;
    run_one("post_rst", bp[1], bpe[1], 1'b0);

    // round trip with random output stalls
    sent = 0;
    rcv = 0;
    rt_bad = 0;
    n = 0;
    cur = gen_legal();
    while (rcv < 10000 && n < 40000) begin
      @(negedge clk);
      drive(cur, sent < 10000);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (rtq.size() > 0) begin
          chk("rt_fields",
              64'(rv32_get_fields(bus.out_inst)),
              64'(rtq.pop_front()));
        end
        if (bus.out_error) rt_bad++;
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        rtq.push_back(cur);
        sent++;
        cur = gen_legal();
      end
      n++;
    end
    chk("rt_done", 64'(rcv), 64'(10000));
    chk("rt_err", 64'(rt_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
